// File: rtl/btn_conditioner_if.sv
// Button-side bundle for btn_conditioner: raw inputs and per-channel conditioned outputs.
// master = the environment that drives the buttons; slave = the conditioner itself.
interface btn_conditioner_if #(
   parameter int CHANNELS = 5
);
   logic [CHANNELS-1:0] in_btn;
   logic [CHANNELS-1:0] out_btn;
   logic [CHANNELS-1:0] press_pulse;
   logic [CHANNELS-1:0] release_pulse;
   logic [CHANNELS-1:0] long_pulse;
   logic [CHANNELS-1:0] held;
   logic [CHANNELS-1:0] rpt_pulse;

   modport master (
      output in_btn,
      input  out_btn, press_pulse, release_pulse, long_pulse, held, rpt_pulse
   );

   modport slave (
      input  in_btn,
      output out_btn, press_pulse, release_pulse, long_pulse, held, rpt_pulse
   );
endinterface

// File: rtl/btn_conditioner.sv
// Per-channel synchroniser, debouncer and press/release/long-press/auto-repeat event generator.
// Each channel is fully independent; events are single-cycle registered pulses.
module btn_conditioner #(
   parameter int CHANNELS      = 5,
   parameter int N             = 11,
   parameter int HOLD_CYCLES   = 38000000,
   parameter int REPEAT_CYCLES = 9500000
) (
   input  logic             clk,
   input  logic             reset,
   btn_conditioner_if.slave bif
);
   localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int HW       = $clog2(HOLD_MAX + 1);

   localparam logic [N-1:0]  CNT_MAX   = N'((1 << (N - 1)) - 1);
   localparam logic [N-1:0]  CNT_ONE   = N'(1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES);
   localparam logic [HW-1:0] RPT_LAST  = HW'(REPEAT_CYCLES);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } state_t;

   logic [CHANNELS-1:0] out_btn_v;
   logic [CHANNELS-1:0] press_v;
   logic [CHANNELS-1:0] release_v;
   logic [CHANNELS-1:0] long_v;
   logic [CHANNELS-1:0] held_v;
   logic [CHANNELS-1:0] rpt_v;

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic          sync1_q, sync1_d, sync2_q, sync2_d;
         logic          stable_q, stable_d;
         logic [N-1:0]  cnt_q, cnt_d;
         state_t        state_q, state_d;
         logic [HW-1:0] hold_cnt_q, hold_cnt_d;
         logic          press_q, press_d, release_q, release_d;
         logic          long_q, long_d, rpt_q, rpt_d;
         logic          accept;

         always_comb begin
            sync1_d    = bif.in_btn[gi];
            sync2_d    = sync1_q;
            stable_d   = stable_q;
            cnt_d      = '0;
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            long_d     = 1'b0;
            rpt_d      = 1'b0;

            // The FSM reacts to the edge on which stable flips, so events line up with out_btn.
            accept = (sync2_q != stable_q) && (cnt_q == CNT_MAX);

            if (sync2_q != stable_q) begin
               if (accept) begin
                  stable_d = sync2_q;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end

            case (state_q)
               IDLE: begin
                  if (accept && sync2_q) begin
                     state_d    = PRESSED;
                     hold_cnt_d = HOLD_ONE;
                     press_d    = 1'b1;
                     rpt_d      = 1'b1;
                  end
               end
               PRESSED: begin
                  if (accept && !sync2_q) begin
                     state_d    = IDLE;
                     hold_cnt_d = '0;
                     release_d  = 1'b1;
                  end else if (hold_cnt_q == HOLD_LAST) begin
                     state_d    = HELD;
                     hold_cnt_d = HOLD_ONE;
                     long_d     = 1'b1;
                     rpt_d      = 1'b1;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HOLD_ONE;
                  end
               end
               HELD: begin
                  if (accept && !sync2_q) begin
                     state_d    = IDLE;
                     hold_cnt_d = '0;
                     release_d  = 1'b1;
                  end else if (hold_cnt_q == RPT_LAST) begin
                     hold_cnt_d = HOLD_ONE;
                     rpt_d      = 1'b1;
                  end else begin
                     hold_cnt_d = hold_cnt_q + HOLD_ONE;
                  end
               end
               default: begin
                  state_d    = IDLE;
                  hold_cnt_d = '0;
               end
            endcase
         end

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync1_q    <= 1'b0;
               sync2_q    <= 1'b0;
               stable_q   <= 1'b0;
               cnt_q      <= '0;
               state_q    <= IDLE;
               hold_cnt_q <= '0;
               press_q    <= 1'b0;
               release_q  <= 1'b0;
               long_q     <= 1'b0;
               rpt_q      <= 1'b0;
            end else begin
               sync1_q    <= sync1_d;
               sync2_q    <= sync2_d;
               stable_q   <= stable_d;
               cnt_q      <= cnt_d;
               state_q    <= state_d;
               hold_cnt_q <= hold_cnt_d;
               press_q    <= press_d;
               release_q  <= release_d;
               long_q     <= long_d;
               rpt_q      <= rpt_d;
            end
         end

         assign out_btn_v[gi] = stable_q;
         assign press_v[gi]   = press_q;
         assign release_v[gi] = release_q;
         assign long_v[gi]    = long_q;
         assign held_v[gi]    = (state_q == HELD);
         assign rpt_v[gi]     = rpt_q;
      end
   endgenerate

   assign bif.out_btn       = out_btn_v;
   assign bif.press_pulse   = press_v;
   assign bif.release_pulse = release_v;
   assign bif.long_pulse    = long_v;
   assign bif.held          = held_v;
   assign bif.rpt_pulse     = rpt_v;
endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner (2 channels, N=3, hold 10, repeat 4): expected
// output snapshots are derived from event-timing formulas and compared after every edge.
module tb_btn_conditioner;
   localparam int CH   = 2;
   localparam int HOLD = 10;
   localparam int RPT  = 4;
   localparam int NEVER = 1000;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;
   logic [11:0] sb[$];

   btn_conditioner_if #(.CHANNELS(CH)) bif ();

   btn_conditioner #(
      .CHANNELS(CH),
      .N(3),
      .HOLD_CYCLES(HOLD),
      .REPEAT_CYCLES(RPT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bif(bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Snapshot layout: {out_btn, press, release, long, held, rpt}, each {ch1, ch0}.
   function automatic logic [11:0] obs();
      return {bif.out_btn, bif.press_pulse, bif.release_pulse,
              bif.long_pulse, bif.held, bif.rpt_pulse};
   endfunction

   // Expected {out, press, release, long, held, rpt} at edge t for a press accepted at p
   // and a release accepted at r (r > p).
   function automatic logic [5:0] ch_exp(int t, int p, int r);
      logic act, hld, rp;
      act = (t >= p) && (t < r);
      hld = act && (t >= p + HOLD);
      rp  = act && ((t == p) || (hld && (((t - p - HOLD) % RPT) == 0)));
      return {act, (t == p), (t == r), act && (t == p + HOLD), hld, rp};
   endfunction

   function automatic logic [11:0] pack(logic [5:0] a, logic [5:0] b);
      logic [11:0] v;
      for (int i = 0; i < 6; i++) begin
         v[2*i]   = a[i];
         v[2*i+1] = b[i];
      end
      return v;
   endfunction

   // Drive the value the DUT samples at the next edge and queue the expected snapshot.
   task automatic step(input logic [1:0] btn, input logic [11:0] want);
      bif.in_btn = btn;
      sb.push_back(want);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [11:0] want;
      #1;
      tests_run++;
      if (obs() !== 12'h000) begin
         tests_failed++;
         $display("FAIL reset_async got=%03h want=000", obs());
      end
      for (int t = 1; t <= 4; t++) begin
         step(2'b11, 12'h000);
         want = sb.pop_front();
         tests_run++;
         if (obs() !== want) begin
            tests_failed++;
            $display("FAIL reset_held t=%0d got=%03h want=%03h", t, obs(), want);
         end
      end
      reset = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         step((t <= 7) ? 2'b11 : 2'b00, pack(ch_exp(t, 6, 13), ch_exp(t, 6, 13)));
         want = sb.pop_front();
         tests_run++;
         if (obs() !== want) begin
            tests_failed++;
            $display("FAIL reset_release t=%0d got=%03h want=%03h", t, obs(), want);
         end
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_clean_press();
      logic [11:0] want;
      for (int t = 1; t <= 30; t++) begin
         step((t >= 10 && t <= 16) ? 2'b01 : 2'b00,
              pack(ch_exp(t, 15, 22), ch_exp(t, NEVER, 2 * NEVER)));
         want = sb.pop_front();
         tests_run++;
         if (obs() !== want) begin
            tests_failed++;
            $display("FAIL clean_press t=%0d got=%03h want=%03h", t, obs(), want);
         end
      end
      $display("[TB] test_clean_press done");
   endtask

   task automatic test_bounce();
      logic [11:0] want;
      logic [1:0]  b;
      for (int t = 1; t <= 16; t++) begin
         b[0] = (t <= 3) || (t >= 5 && t <= 7);
         b[1] = (t >= 2 && t <= 4);
         step(b, 12'h000);
         want = sb.pop_front();
         tests_run++;
         if (obs() !== want) begin
            tests_failed++;
            $display("FAIL bounce t=%0d got=%03h want=%03h", t, obs(), want);
         end
      end
      $display("[TB] test_bounce done");
   endtask

   task automatic test_long_press();
      logic [11:0] want;
      logic [1:0]  b;
      for (int t = 1; t <= 42; t++) begin
         b[0] = (t <= 29);
         b[1] = (t >= 5 && t <= 12);
         step(b, pack(ch_exp(t, 6, 35), ch_exp(t, 10, 18)));
         want = sb.pop_front();
         tests_run++;
         if (obs() !== want) begin
            tests_failed++;
            $display("FAIL long_press t=%0d got=%03h want=%03h", t, obs(), want);
         end
      end
      $display("[TB] test_long_press done");
   endtask

   task automatic test_release_at_expiry();
      logic [11:0] want;
      for (int t = 1; t <= 24; t++) begin
         step((t <= 10) ? 2'b01 : 2'b00,
              pack(ch_exp(t, 6, 16), ch_exp(t, NEVER, 2 * NEVER)));
         want = sb.pop_front();
         tests_run++;
         if (obs() !== want) begin
            tests_failed++;
            $display("FAIL release_at_expiry t=%0d got=%03h want=%03h", t, obs(), want);
         end
      end
      $display("[TB] test_release_at_expiry done");
   endtask

   task automatic test_reset_mid_hold();
      logic [11:0] want;
      for (int t = 1; t <= 18; t++) begin
         step(2'b10, pack(ch_exp(t, NEVER, 2 * NEVER), ch_exp(t, 6, NEVER)));
         want = sb.pop_front();
         tests_run++;
         if (obs() !== want) begin
            tests_failed++;
            $display("FAIL mid_hold_pre t=%0d got=%03h want=%03h", t, obs(), want);
         end
      end
      #2 reset = 1'b0;
      #1;
      tests_run++;
      if (obs() !== 12'h000) begin
         tests_failed++;
         $display("FAIL mid_hold_async got=%03h want=000", obs());
      end
      for (int t = 1; t <= 3; t++) begin
         step(2'b10, 12'h000);
         want = sb.pop_front();
         tests_run++;
         if (obs() !== want) begin
            tests_failed++;
            $display("FAIL mid_hold_in_reset t=%0d got=%03h want=%03h", t, obs(), want);
         end
      end
      reset = 1'b1;
      for (int t = 1; t <= 20; t++) begin
         step((t <= 7) ? 2'b10 : 2'b00,
              pack(ch_exp(t, NEVER, 2 * NEVER), ch_exp(t, 6, 13)));
         want = sb.pop_front();
         tests_run++;
         if (obs() !== want) begin
            tests_failed++;
            $display("FAIL mid_hold_repress t=%0d got=%03h want=%03h", t, obs(), want);
         end
      end
      $display("[TB] test_reset_mid_hold done");
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b0;
      bif.in_btn   = 2'b11;
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_press();
      test_release_at_expiry();
      test_reset_mid_hold();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

Multi-channel successor to the single-input debouncer: a synchroniser, debouncer and press-event generator for CHANNELS independent active-high push buttons. Each channel delivers a clean level, one-cycle press/release pulses, a long-press indication and an auto-repeat pulse train. It sits between the board buttons and the alarm-clock control FSM, which consumes only single-cycle events.

## Interface
- CHANNELS, 5: number of independent button channels (≥1).
- N, 11: debounce counter width. The input must differ from the stable level for 2^(N-1) consecutive cycles to be accepted (≥2).
- HOLD_CYCLES, 38000000: cycles from accepted press to long-press detection (≥2).
- REPEAT_CYCLES, 9500000: auto-repeat period while held (≥1).

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_btn  in  CHANNELS  raw asynchronous button inputs, active-high.
- out_btn  out  CHANNELS  debounced level.
- press_pulse  out  CHANNELS  one-cycle pulse on accepted 0→1.
- release_pulse  out  CHANNELS  one-cycle pulse on accepted 1→0.
- long_pulse  out  CHANNELS  one-cycle pulse when a press reaches HOLD_CYCLES.
- held  out  CHANNELS  level, high while the channel is in HELD.
- rpt_pulse  out  CHANNELS  auto-repeat event pulse.

## Operation
- Channels are fully independent. Per-channel logic is replicated via generate, with no shared counters.
- Synchroniser: two flip-flops per channel (sync1, sync2), reset to 0.
- Debounce, per channel, with stable register and N-bit cnt:
  - sync2 == stable: cnt ← 0.
  - sync2 ≠ stable and cnt < 2^(N-1)-1: cnt ← cnt+1.
  - sync2 ≠ stable and cnt == 2^(N-1)-1: stable ← sync2, cnt ← 0.
  - Any single-cycle return to the stable level restarts the count.
- out_btn = stable, driven from a register.
- Event FSM per channel, states IDLE, PRESSED, HELD. hold_cnt is sized $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)+1).
  - IDLE: on stable 0→1, go to PRESSED, hold_cnt ← 1, press_pulse = 1, rpt_pulse = 1.
  - PRESSED: if stable falls, go to IDLE and release_pulse = 1. Otherwise, if hold_cnt == HOLD_CYCLES, go to HELD, hold_cnt ← 1, long_pulse = 1, rpt_pulse = 1. Otherwise hold_cnt++.
  - HELD: if stable falls, go to IDLE and release_pulse = 1. Otherwise, if hold_cnt == REPEAT_CYCLES, hold_cnt ← 1 and rpt_pulse = 1. Otherwise hold_cnt++.
- held is high exactly while state == HELD.
- Release has priority. On a release edge no long_pulse or rpt_pulse is issued, even if the counter expires on the same edge.
- All pulse outputs are registered and last exactly one cycle.

## Timing
- Reset asserted: all flops clear immediately and asynchronously. Every output is 0, the FSM is IDLE, and all counters are 0.
- Reset released while in_btn is high: this is treated as a new press. After the full latency it produces out_btn = 1 and press_pulse.
- Press/release latency: an in_btn change sampled at edge k gives out_btn and press_pulse/release_pulse visible after edge k+1+2^(N-1).
- press_pulse and the first rpt_pulse coincide with out_btn rising.
- With press accepted at edge P:
  - long_pulse, held rising and rpt_pulse occur at edge P+HOLD_CYCLES.
  - Further rpt_pulse occurs at edges P+HOLD_CYCLES+j·REPEAT_CYCLES, for j ≥ 1.
- held falls at the same edge that release_pulse rises.
- A bounce shorter than 2^(N-1) consecutive cycles never changes out_btn.
- Counters never wrap. cnt saturates by design, and hold_cnt is reloaded to 1 before overflow.

## Test plan
All scenarios use CHANNELS=2, N=3, HOLD_CYCLES=10, REPEAT_CYCLES=4.

- Reset: reset=0 with in_btn=2'b11. All outputs stay 0 throughout. Release reset at edge 0 → out_btn[0] and press_pulse[0] go high after edge 6.
- Clean press on ch0 at sample edge 10 → out_btn[0]=1 and press_pulse[0]=rpt_pulse[0]=1 after edge 15. Both pulses are 0 after edge 16. Ch1 stays 0.
- Bounce: in_btn[0] high for 3 cycles, low for 1, high for 3, then low → out_btn[0] never rises, and no pulse of any kind.
- Long press held 30 cycles after acceptance at P:
  - long_pulse and held rise at P+10.
  - rpt_pulse at P, P+10, P+14, P+18, P+22, P+26.
  - Release after that gives held=0 and release_pulse together.
- Release coincident with hold expiry (stable falls at P+10) → release_pulse=1, long_pulse=0, rpt_pulse=0, FSM returns to IDLE.
- Reset mid-hold: assert reset while held[1]=1 → all outputs 0 asynchronously. After deassertion with in_btn[1] still high → a new press_pulse[1] after full latency.
